// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART sender between NREQ byte sources.
// Each frame runs accept -> start -> wait busy -> wait done, then a forced idle gap.
module uart_tx_scheduler #(
   parameter int NREQ          = 2,
   parameter int GAP_CYCLES    = 162,
   parameter int START_TIMEOUT = 4096
) (
   input  logic                                      sysclk,
   input  logic                                      reset,
   input  logic [NREQ-1:0]                           req_valid,
   input  logic [8*NREQ-1:0]                         req_data,
   output logic [NREQ-1:0]                           req_ready,
   output logic                                      tx_start,
   output logic [7:0]                                tx_data,
   input  logic                                      tx_busy,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
   output logic                                      err_timeout,
   output logic                                      sched_busy,
   output logic [1:0]                                dbg_state
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TW = $clog2(START_TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_rr_ptr;
   logic [GW-1:0]     r_gap_cnt;
   logic [TW-1:0]     r_timer;
   logic [IW-1:0]     r_grant;
   logic [7:0]        r_tx_data;
   logic [NREQ-1:0]   r_req_ready;
   logic              r_tx_start;
   logic              r_err;

   state_t            w_state_nxt;
   logic [IW-1:0]     w_rr_nxt;
   logic [GW-1:0]     w_gap_nxt;
   logic [TW-1:0]     w_timer_nxt;
   logic [IW-1:0]     w_grant_nxt;
   logic [7:0]        w_data_nxt;
   logic [NREQ-1:0]   w_ready_nxt;
   logic              w_start_nxt;
   logic              w_err_nxt;

   logic              w_hi_any;
   logic [IW-1:0]     w_hi_idx;
   logic              w_lo_any;
   logic [IW-1:0]     w_lo_idx;
   logic [IW-1:0]     w_pick_idx;
   logic [NREQ-1:0]   w_pick_oh;
   logic [7:0]        w_pick_data;

   // Lowest valid index at or above rr_ptr wins; otherwise wrap to lowest valid overall.
   always_comb begin
      w_hi_any = 1'b0;
      w_hi_idx = '0;
      w_lo_any = 1'b0;
      w_lo_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            w_lo_any = 1'b1;
            w_lo_idx = IW'(i);
            if (IW'(i) >= r_rr_ptr) begin
               w_hi_any = 1'b1;
               w_hi_idx = IW'(i);
            end
         end
      end
   end

   assign w_pick_idx = w_hi_any ? w_hi_idx : w_lo_idx;

   always_comb begin
      w_pick_oh   = '0;
      w_pick_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IW'(i) == w_pick_idx) begin
            w_pick_oh[i] = 1'b1;
            w_pick_data  = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_gap_nxt   = r_gap_cnt;
      w_timer_nxt = r_timer;
      w_grant_nxt = r_grant;
      w_data_nxt  = r_tx_data;
      w_ready_nxt = '0;
      w_start_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_gap_cnt != '0) begin
               w_gap_nxt = r_gap_cnt - GW'(1);
            end else if (w_lo_any) begin
               w_data_nxt  = w_pick_data;
               w_grant_nxt = w_pick_idx;
               w_ready_nxt = w_pick_oh;
               w_start_nxt = 1'b1;
               w_rr_nxt    = (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + IW'(1);
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_timer_nxt = '0;
            w_state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_timer == TW'(START_TIMEOUT - 1)) begin
               // Sender never acknowledged: drop the byte and still honour the gap.
               w_err_nxt   = 1'b1;
               w_gap_nxt   = GW'(GAP_CYCLES);
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               w_gap_nxt   = GW'(GAP_CYCLES);
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_gap_cnt   <= '0;
         r_timer     <= '0;
         r_grant     <= '0;
         r_tx_data   <= '0;
         r_req_ready <= '0;
         r_tx_start  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_nxt;
         r_gap_cnt   <= w_gap_nxt;
         r_timer     <= w_timer_nxt;
         r_grant     <= w_grant_nxt;
         r_tx_data   <= w_data_nxt;
         r_req_ready <= w_ready_nxt;
         r_tx_start  <= w_start_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign req_ready   = r_req_ready;
   assign tx_start    = r_tx_start;
   assign tx_data     = r_tx_data;
   assign grant_id    = r_grant;
   assign err_timeout = r_err;
   assign sched_busy  = (r_state != S_IDLE);
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: stimulus pushes expected grants, monitors pop them on tx_start.
// Instance a: NREQ=2, GAP=162; instance b: NREQ=3, GAP=0.
module tb_uart_tx_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [1:0]  a_valid;
   logic [15:0] a_data;
   logic [1:0]  a_ready;
   logic        a_tx_start;
   logic [7:0]  a_tx_data;
   logic        a_busy;
   logic [0:0]  a_grant;
   logic        a_err;
   logic        a_sbusy;
   logic [1:0]  a_dbg;

   logic [2:0]  b_valid;
   logic [23:0] b_data;
   logic [2:0]  b_ready;
   logic        b_tx_start;
   logic [7:0]  b_tx_data;
   logic        b_busy;
   logic [1:0]  b_grant;
   logic        b_err;
   logic        b_sbusy;
   logic [1:0]  b_dbg;

   uart_tx_scheduler dut_a (
      .sysclk(clk), .reset(rst), .req_valid(a_valid), .req_data(a_data),
      .req_ready(a_ready), .tx_start(a_tx_start), .tx_data(a_tx_data),
      .tx_busy(a_busy), .grant_id(a_grant), .err_timeout(a_err),
      .sched_busy(a_sbusy), .dbg_state(a_dbg)
   );

   uart_tx_scheduler #(.NREQ(3), .GAP_CYCLES(0)) dut_b (
      .sysclk(clk), .reset(rst), .req_valid(b_valid), .req_data(b_data),
      .req_ready(b_ready), .tx_start(b_tx_start), .tx_data(b_tx_data),
      .tx_busy(b_busy), .grant_id(b_grant), .err_timeout(b_err),
      .sched_busy(b_sbusy), .dbg_state(b_dbg)
   );

   // Entry layout: [15:12] req_ready one-hot, [11:8] grant_id, [7:0] tx_data.
   logic [15:0] a_exp_q[$];
   logic [15:0] b_exp_q[$];
   logic [15:0] a_e;
   logic [15:0] b_e;

   bit a_busy_en   = 1'b1;
   int a_fall_cyc  = 0;
   int a_err_cnt   = 0;
   int a_err_cyc   = 0;
   int b_fall_cyc  = 0;
   bit b_have_fall = 1'b0;
   int b_nregrant  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ent(input logic [3:0] oh, input logic [3:0] g, input logic [7:0] d);
      return {oh, g, d};
   endfunction

   task automatic bound_fail(input string name, input int budget);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
   endtask

   task automatic wait_a_ready(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (a_ready != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail("wait_a_ready", budget);
   endtask

   task automatic wait_a_err(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (a_err) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail("wait_a_err", budget);
   endtask

   task automatic wait_a_busy(input logic lvl, input int budget);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (a_busy == lvl) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail("wait_a_busy", budget);
   endtask

   task automatic a_settle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (!a_sbusy && !a_busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail("a_settle", budget);
   endtask

   task automatic wait_q_empty(input bit sel_b, input int budget);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if ((sel_b ? b_exp_q.size() : a_exp_q.size()) == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail(sel_b ? "wait_b_queue" : "wait_a_queue", budget);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Sender models: busy rises 2 cycles after the start pulse.
   initial begin
      a_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (a_tx_start && a_busy_en) begin
            @(posedge clk);
            @(posedge clk);
            #1 a_busy = 1'b1;
            repeat (100) @(posedge clk);
            #1 a_busy = 1'b0;
            a_fall_cyc = cyc;
         end
      end
   end

   initial begin
      b_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (b_tx_start) begin
            @(posedge clk);
            @(posedge clk);
            #1 b_busy = 1'b1;
            repeat (5) @(posedge clk);
            #1 b_busy = 1'b0;
            b_fall_cyc  = cyc;
            b_have_fall = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (a_tx_start || a_ready != 2'b00)
         check("a_start_ready_align", 32'(a_tx_start), 32'(a_ready != 2'b00));
      if (a_tx_start) begin
         if (a_exp_q.size() == 0) begin
            check("a_unexpected_start", 32'(1), 32'(0));
         end else begin
            a_e = a_exp_q.pop_front();
            check("a_grant_id", 32'(a_grant), 32'(a_e[11:8]));
            check("a_tx_data", 32'(a_tx_data), 32'(a_e[7:0]));
            check("a_req_ready", 32'(a_ready), 32'(a_e[15:12]));
         end
      end
      if (a_err) begin
         a_err_cnt++;
         a_err_cyc = cyc;
      end
   end

   always @(negedge clk) begin
      if (b_tx_start) begin
         if (b_exp_q.size() == 0) begin
            check("b_unexpected_start", 32'(1), 32'(0));
         end else begin
            b_e = b_exp_q.pop_front();
            check("b_grant_id", 32'(b_grant), 32'(b_e[11:8]));
            check("b_tx_data", 32'(b_tx_data), 32'(b_e[7:0]));
            check("b_req_ready", 32'(b_ready), 32'(b_e[15:12]));
         end
         if (b_have_fall) begin
            // busy low in cycle F -> IDLE decides in F+1 -> ready in F+2
            check("b_regrant_gap", cyc - b_fall_cyc, 2);
            b_have_fall = 1'b0;
            b_nregrant++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int t0;
      int e_cyc;
      a_valid = '0;
      a_data  = '0;
      b_valid = '0;
      b_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(a_ready), 0);
      check("rst_tx_start", 32'(a_tx_start), 0);
      check("rst_tx_data", 32'(a_tx_data), 0);
      check("rst_grant_id", 32'(a_grant), 0);
      check("rst_err", 32'(a_err), 0);
      check("rst_sched_busy", 32'(a_sbusy), 0);
      check("rst_b_sched_busy", 32'(b_sbusy), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Test 1: single requester, latency and inter-frame gap
      @(posedge clk);
      #1;
      a_data[7:0] = 8'h55;
      a_exp_q.push_back(ent(4'b0001, 4'd0, 8'h55));
      a_valid = 2'b01;
      t0 = cyc;
      wait_a_ready(50, ok);
      if (ok) check("t1_latency", cyc - t0, 1);
      a_valid = 2'b00;
      @(negedge clk);
      check("t1_start_one_cycle", 32'(a_tx_start), 0);
      check("t1_ready_one_cycle", 32'(a_ready), 0);
      check("t1_tx_data_hold", 32'(a_tx_data), 32'h55);
      check("t1_sched_busy", 32'(a_sbusy), 1);
      a_data[7:0] = 8'h56;
      a_exp_q.push_back(ent(4'b0001, 4'd0, 8'h56));
      a_valid = 2'b01;
      wait_a_ready(500, ok);
      // busy low in cycle F -> gap load in F+1 -> 162 idle cycles -> ready in F+164
      if (ok) check("t1_gap", cyc - a_fall_cyc, 164);
      a_valid = 2'b00;
      a_settle(400);

      // Test 2: both requesters held valid, alternate grants
      do_reset();
      a_data = {8'h3C, 8'hA5};
      a_exp_q.push_back(ent(4'b0001, 4'd0, 8'hA5));
      a_exp_q.push_back(ent(4'b0010, 4'd1, 8'h3C));
      a_exp_q.push_back(ent(4'b0001, 4'd0, 8'hA5));
      a_exp_q.push_back(ent(4'b0010, 4'd1, 8'h3C));
      a_valid = 2'b11;
      wait_q_empty(1'b0, 2000);
      a_valid = 2'b00;
      a_settle(600);

      // Test 3: sender never goes busy -> start timeout
      do_reset();
      a_busy_en = 1'b0;
      a_exp_q.push_back(ent(4'b0001, 4'd0, 8'hA5));
      a_valid = 2'b11;
      wait_a_ready(50, ok);
      t0 = cyc;
      e_cyc = cyc;
      wait_a_err(4300, ok);
      if (ok) begin
         // ISSUE in S, WAIT_BUSY entered S+1, timer hits 4095 in S+4096, pulse in S+4097
         check("t3_err_time", cyc - t0, 4097);
         check("t3_idle_on_err", 32'(a_sbusy), 0);
         e_cyc = cyc;
         @(negedge clk);
         check("t3_err_one_cycle", 32'(a_err), 0);
      end
      a_exp_q.push_back(ent(4'b0010, 4'd1, 8'h3C));
      wait_a_ready(300, ok);
      if (ok) check("t3_regrant_after_gap", cyc - e_cyc, 163);
      a_valid = 2'b00;
      do_reset();
      a_busy_en = 1'b1;
      check("t3_err_count", a_err_cnt, 1);

      // Test 4: reset in WAIT_DONE
      a_exp_q.push_back(ent(4'b0001, 4'd0, 8'hA5));
      a_valid = 2'b01;
      wait_a_ready(50, ok);
      a_valid = 2'b00;
      wait_a_busy(1'b1, 20);
      repeat (3) @(negedge clk);
      check("t4_pre_sched_busy", 32'(a_sbusy), 1);
      check("t4_pre_state", 32'(a_dbg), 3);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("t4_rst_req_ready", 32'(a_ready), 0);
      check("t4_rst_tx_start", 32'(a_tx_start), 0);
      check("t4_rst_tx_data", 32'(a_tx_data), 0);
      check("t4_rst_grant", 32'(a_grant), 0);
      check("t4_rst_err", 32'(a_err), 0);
      check("t4_rst_sched_busy", 32'(a_sbusy), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      wait_a_busy(1'b0, 200);
      a_exp_q.push_back(ent(4'b0001, 4'd0, 8'hA5));
      a_valid = 2'b11;
      wait_a_ready(50, ok);
      a_valid = 2'b00;
      a_settle(600);

      // Test 5: NREQ=3, GAP=0, only requester 2 valid, back-to-back
      b_data = {8'h9E, 8'h22, 8'h11};
      for (int k = 0; k < 3; k++) b_exp_q.push_back(ent(4'b0100, 4'd2, 8'h9E));
      @(posedge clk);
      #1 b_valid = 3'b100;
      wait_q_empty(1'b1, 200);
      b_valid = 3'b000;
      repeat (30) @(negedge clk);
      check("t5_regrant_count", b_nregrant, 2);
      check("t5_no_err", 32'(b_err), 0);

      check("end_a_queue_empty", a_exp_q.size(), 0);
      check("end_b_queue_empty", b_exp_q.size(), 0);
      check("end_a_err_count", a_err_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
